// File: rtl/oled_pkg.sv
// oled_pkg: shared arbiter state encoding and SSD1306/I2C constants
package oled_pkg;
   typedef enum logic [1:0] {IDLE, GRANTED, BUSY} arb_state_t;
   localparam logic [7:0] OLED_CTRL_CMD       = 8'h00;
   localparam logic [7:0] OLED_CTRL_DATA      = 8'h40;
   localparam logic [6:0] OLED_I2C_ADDR       = 7'h3C;
   localparam int         OLED_TIMEOUT_CYCLES = 50000;
endpackage

// File: rtl/oled_watchdog.sv
// oled_watchdog: clearable up-counter; o_tc high while counting at LIMIT-1 (i_clk, i_rst_n, i_clr, i_en -> o_tc)
module oled_watchdog
   import oled_pkg::*;
#(
   parameter int LIMIT = OLED_TIMEOUT_CYCLES,
   parameter int W     = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);
   logic [W-1:0] r_cnt;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_cnt <= '0;
      else r_cnt <= i_clr ? '0 : i_en ? r_cnt + W'(1) : r_cnt;
   assign o_tc = i_en && (r_cnt == W'(LIMIT - 1));
endmodule

// File: rtl/oled_i2c_arb.sv
// oled_i2c_arb: round-robin arbiter with locked bursts and watchdog for the OLED I2C write engine (2 requesters: req/lock/wr_en/addr/data in; gnt/req_done/err_timeout/reg_addr/reg_data/write_i2c_en out; i2c_done in)
module oled_i2c_arb
   import oled_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = OLED_TIMEOUT_CYCLES,
   parameter int TMR_W          = 16
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_req,
   input  logic [1:0] i_lock,
   input  logic [1:0] i_wr_en,
   input  logic [7:0] i_addr0,
   input  logic [7:0] i_data0,
   input  logic [7:0] i_addr1,
   input  logic [7:0] i_data1,
   output logic [1:0] o_gnt,
   output logic [1:0] o_req_done,
   output logic       o_err_timeout,
   output logic [7:0] o_reg_addr,
   output logic [7:0] o_reg_data,
   output logic       o_write_i2c_en,
   input  logic       i_i2c_done
);
   arb_state_t r_state;
   logic       r_own, r_rr;
   logic [1:0] r_gnt, r_done;
   logic [7:0] r_addr, r_data;
   logic       r_wr, r_err;
   logic       w_win, w_issue, w_tc;
   // a lone requester wins outright; rr pointer only breaks ties
   assign w_win   = (&i_req) ? r_rr : i_req[1];
   assign w_issue = (r_state == GRANTED) && i_wr_en[r_own];
   oled_watchdog #(.LIMIT(TIMEOUT_CYCLES), .W(TMR_W)) u_wdog (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_clr  (w_issue),
      .i_en   (r_state == BUSY),
      .o_tc   (w_tc)
   );
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_own   <= 1'b0;
         r_rr    <= 1'b0;
         r_gnt   <= 2'b00;
         r_done  <= 2'b00;
         r_addr  <= 8'h00;
         r_data  <= 8'h00;
         r_wr    <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_wr   <= 1'b0;
         r_done <= 2'b00;
         r_err  <= 1'b0;
         case (r_state)
            IDLE:
               if (|i_req) begin
                  r_own   <= w_win;
                  r_gnt   <= w_win ? 2'b10 : 2'b01;
                  r_state <= GRANTED;
               end
            GRANTED:
               if (w_issue) begin
                  r_addr  <= r_own ? i_addr1 : i_addr0;
                  r_data  <= r_own ? i_data1 : i_data0;
                  r_wr    <= 1'b1;
                  r_state <= BUSY;
               end else if (!i_req[r_own]) begin
                  r_gnt   <= 2'b00;
                  r_rr    <= ~r_own;
                  r_state <= IDLE;
               end
            BUSY:
               // completion takes priority over a coincident watchdog expiry
               if (i_i2c_done) begin
                  r_done <= r_gnt;
                  if (i_lock[r_own] && i_req[r_own]) r_state <= GRANTED;
                  else begin
                     r_gnt   <= 2'b00;
                     r_rr    <= ~r_own;
                     r_state <= IDLE;
                  end
               end else if (w_tc) begin
                  r_err   <= 1'b1;
                  r_gnt   <= 2'b00;
                  r_rr    <= ~r_own;
                  r_state <= IDLE;
               end
            default: r_state <= IDLE;
         endcase
      end
   assign o_gnt          = r_gnt;
   assign o_req_done     = r_done;
   assign o_err_timeout  = r_err;
   assign o_reg_addr     = r_addr;
   assign o_reg_data     = r_data;
   assign o_write_i2c_en = r_wr;
endmodule

// File: tb/tb_oled_i2c_arb.sv
// tb_oled_i2c_arb: scoreboard bench for oled_i2c_arb (writes and completions checked against queued expectations)
module tb_oled_i2c_arb;
   import oled_pkg::*;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic [1:0] req = '0, lock = '0, wr_en = '0;
   logic [7:0] addr0 = '0, data0 = '0, addr1 = '0, data1 = '0;
   logic       i2c_done = 1'b0;
   logic [1:0] gnt, req_done;
   logic       err_timeout, write_i2c_en;
   logic [7:0] reg_addr, reg_data;
   int         n_chk = 0, n_fail = 0;
   logic [15:0] exp_wr[$];
   logic [1:0]  exp_done[$];

   oled_i2c_arb #(.TIMEOUT_CYCLES(16), .TMR_W(16)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_lock(lock), .i_wr_en(wr_en),
      .i_addr0(addr0), .i_data0(data0), .i_addr1(addr1), .i_data1(data1),
      .o_gnt(gnt), .o_req_done(req_done), .o_err_timeout(err_timeout),
      .o_reg_addr(reg_addr), .o_reg_data(reg_data), .o_write_i2c_en(write_i2c_en),
      .i_i2c_done(i2c_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // owner i issues one write, engine answers lat cycles after the strobe
   task automatic wr(input int i, input logic [7:0] a, input logic [7:0] d, input int lat);
      wr_en[i] = 1'b1;
      if (i == 1) begin addr1 = a; data1 = d; end
      else begin addr0 = a; data0 = d; end
      exp_wr.push_back({a, d});
      tick();
      wr_en = '0;
      chk("wr_pulse", write_i2c_en, 1'b1);
      repeat (lat) tick();
      i2c_done = 1'b1;
      exp_done.push_back(2'(1 << i));
      tick();
      i2c_done = 1'b0;
      chk("done_no_err", err_timeout, 1'b0);
   endtask

   always @(negedge clk) begin
      if (write_i2c_en) begin
         chk("wr_expected", exp_wr.size() > 0, 1'b1);
         if (exp_wr.size() > 0) chk("wr_addr_data", {reg_addr, reg_data}, exp_wr.pop_front());
      end
      if (|req_done) begin
         chk("done_expected", exp_done.size() > 0, 1'b1);
         if (exp_done.size() > 0) chk("req_done", req_done, exp_done.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL bench_timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      tick();
      tick();
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_addr_data", {reg_addr, reg_data}, 16'h0000);
      chk("rst_strobes", {write_i2c_en, err_timeout, req_done}, 4'h0);
      rst_n = 1'b1;
      tick();
      // single command write from requester 0
      req = 2'b01;
      tick();
      chk("t1_gnt", gnt, 2'b01);
      wr(0, OLED_CTRL_CMD, 8'hAE, 10);
      chk("t1_release", gnt, 2'b00);
      req = 2'b00;
      tick();
      chk("t1_idle", gnt, 2'b00);
      // simultaneous requests from reset: 0 first, then 1
      do_reset();
      req = 2'b11;
      tick();
      chk("t2_gnt0", gnt, 2'b01);
      wr(0, OLED_CTRL_CMD, 8'hA8, 5);
      chk("t2_rel0", gnt, 2'b00);
      tick();
      chk("t2_gnt1", gnt, 2'b10);
      wr(1, OLED_CTRL_DATA, 8'h55, 3);
      chk("t2_rel1", gnt, 2'b00);
      tick();
      chk("t2_gnt0_again", gnt, 2'b01);
      wr(0, OLED_CTRL_CMD, 8'hAF, 2);
      req = 2'b00;
      tick();
      chk("t2_idle", gnt, 2'b00);
      req = 2'b11;
      tick();
      chk("t2_rr_gnt1", gnt, 2'b10);
      // done exactly when the watchdog expires: completion wins
      wr(1, OLED_CTRL_DATA, 8'hAA, 15);
      chk("t2_rel1b", gnt, 2'b00);
      // locked burst from requester 1 while requester 0 waits
      req = 2'b10;
      lock = 2'b10;
      tick();
      chk("t3_gnt1", gnt, 2'b10);
      req = 2'b11;
      wr(1, OLED_CTRL_DATA, 8'hFF, 3);
      chk("t3_hold_a", gnt, 2'b10);
      wr(1, OLED_CTRL_DATA, 8'h0F, 1);
      chk("t3_hold_b", gnt, 2'b10);
      lock = 2'b00;
      wr(1, OLED_CTRL_DATA, 8'hF0, 6);
      chk("t3_rel", gnt, 2'b00);
      req = 2'b01;
      tick();
      chk("t3_gnt0", gnt, 2'b01);
      req = 2'b00;
      tick();
      chk("t3_drop_req", gnt, 2'b00);
      // hung engine: watchdog abort 16 cycles after the strobe
      req = 2'b01;
      tick();
      chk("t4_gnt", gnt, 2'b01);
      wr_en = 2'b01;
      addr0 = OLED_CTRL_CMD;
      data0 = 8'hA4;
      exp_wr.push_back({OLED_CTRL_CMD, 8'hA4});
      tick();
      wr_en = 2'b00;
      chk("t4_wr", write_i2c_en, 1'b1);
      for (int i = 1; i < 16; i++) begin
         tick();
         chk("t4_no_err_yet", {err_timeout, gnt}, 3'b001);
      end
      tick();
      chk("t4_err", err_timeout, 1'b1);
      chk("t4_gnt_clr", gnt, 2'b00);
      chk("t4_no_done", req_done, 2'b00);
      req = 2'b00;
      tick();
      chk("t4_err_pulse", err_timeout, 1'b0);
      chk("t4_hold_data", {reg_addr, reg_data}, {OLED_CTRL_CMD, 8'hA4});
      // ignored inputs, then asynchronous reset mid-transfer
      i2c_done = 1'b1;
      wr_en = 2'b11;
      tick();
      i2c_done = 1'b0;
      wr_en = 2'b00;
      chk("t5_idle_ignore", {write_i2c_en, req_done, gnt}, 5'h00);
      req = 2'b01;
      tick();
      chk("t5_gnt", gnt, 2'b01);
      wr_en = 2'b10;
      tick();
      wr_en = 2'b00;
      chk("t5_nonowner", write_i2c_en, 1'b0);
      wr_en = 2'b01;
      addr0 = 8'h81;
      data0 = 8'h7F;
      exp_wr.push_back(16'h817F);
      tick();
      chk("t5_wr", write_i2c_en, 1'b1);
      tick();
      wr_en = 2'b00;
      chk("t5_busy_ignore", write_i2c_en, 1'b0);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("t5_async_gnt", gnt, 2'b00);
      chk("t5_async_regs", {reg_addr, reg_data}, 16'h0000);
      chk("t5_async_strobes", {write_i2c_en, err_timeout, req_done}, 4'h0);
      req = 2'b00;
      tick();
      rst_n = 1'b1;
      tick();
      chk("wr_queue_empty", exp_wr.size(), 16'd0);
      chk("done_queue_empty", exp_done.size(), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
